// File: rtl/countdown_arb_pkg.sv
// Shared definitions for the countdown arbiter: FSM state encoding and default sizes.
package countdown_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned NREQ_DEF  = 4;

endpackage

// File: rtl/count_core.sv
// Loadable up/down counter with active-low enable and load; load has priority over counting.
module count_core #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_b,
  input  logic         load_b,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!en_b) begin
      if (!load_b)  q <= d;
      else if (up)  q <= q + 1'b1;
      else          q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_arbiter.sv
// Grants one requester at a time and runs a shared countdown of the requested length.
// Define COUNTDOWN_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module countdown_arbiter
  import countdown_arb_pkg::*;
#(
  parameter int unsigned N    = CNT_W_DEF,
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] len_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      cnt
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          state;
  logic [N-1:0]    len_q;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] win_oh;
  logic [N-1:0]    win_len;
  logic            found;
  logic            cnt_zero;
  logic            cnt_en_b;
  logic            cnt_load_b;

`ifdef COUNTDOWN_ARB_RR_EN
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] mask;

  // Requesters at or above the pointer are searched first; if none, wrap to the full set.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i >= 32'(ptr)) mask[i] = 1'b1;
    end
    cand = ((req & mask) != '0) ? (req & mask) : req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == IDLE && req != '0) begin
      ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign cand = req;
`endif

  always_comb begin
    win_oh  = '0;
    win_len = '0;
    found   = 1'b0;
`ifdef COUNTDOWN_ARB_RR_EN
    win_idx = '0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (cand[i] && !found) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_len   = len_in[i*N +: N];
`ifdef COUNTDOWN_ARB_RR_EN
        win_idx   = IW'(i);
`endif
      end
    end
  end

  assign cnt_zero   = (cnt == '0);
  assign cnt_load_b = !(state == LOAD);
  // Counting stops at zero so the counter can never wrap.
  assign cnt_en_b   = !((state == LOAD) || (state == COUNT && !cnt_zero));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            gnt   <= win_oh;
            len_q <= win_len;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: state <= COUNT;
        COUNT: begin
          if (cnt_zero) begin
            done  <= gnt;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  count_core #(.N(N)) u_count_core (
    .clk    (clk),
    .rst    (rst),
    .en_b   (cnt_en_b),
    .load_b (cnt_load_b),
    .up     (1'b0),
    .d      (len_q),
    .q      (cnt)
  );

endmodule

// File: tb/tb_countdown_arbiter.sv
// Scoreboard bench for countdown_arbiter: stimulus pushes expected completions, a monitor pops on done.
module tb_countdown_arbiter;
  import countdown_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  cnt;

  countdown_arbiter #(.N(4), .NREQ(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .len_in (len_in),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .cnt    (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dn;
    int         len;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0] trace[$];
  int checks = 0;
  int errors = 0;
  int ndone = 0;
  int idle_run = 0;
  int cur_gap = 0;
  logic [3:0] prev_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [3:0] dn, input int len, input int gap);
    exp_t e;
    e.dn = dn; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  function automatic int exp_cnt(input int len, input int k);
    if (k == 0) return 0;
    if (k <= len + 1) return len - (k - 1);
    return 0;
  endfunction

  // Monitor: per-cycle invariants plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      trace.delete();
      idle_run = 0;
      prev_cnt = '0;
    end else begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("done_onehot0", 32'($onehot0(done)), 32'd1);
      chk("busy_vs_state", 32'(busy), 32'(dut.state != IDLE));
      chk("done_only_in_DONE", 32'(done != 4'b0), 32'(dut.state == DONE));
      chk("cnt_no_wrap", 32'(prev_cnt == 4'd0 && cnt == 4'hF), 32'd0);
      prev_cnt = cnt;
      if (gnt == 4'b0) begin
        idle_run++;
        trace.delete();
      end else begin
        if (trace.size() == 0) cur_gap = idle_run;
        idle_run = 0;
        trace.push_back(cnt);
      end
      if (done != 4'b0) begin
        ndone++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          int bad;
          e = exp_q.pop_front();
          chk("done_vec", 32'(done), 32'(e.dn));
          chk("gnt_at_done", 32'(gnt), 32'(e.dn));
          chk("gnt_cycles", 32'(trace.size()), 32'(e.len + 3));
          bad = 0;
          for (int k = 0; k < trace.size(); k++)
            if (32'(trace[k]) != 32'(exp_cnt(e.len, k))) bad++;
          chk("cnt_trace_bad_entries", 32'(bad), 32'd0);
          if (e.gap >= 0) chk("idle_gap", 32'(cur_gap), 32'(e.gap));
        end
      end
    end
  end

  task automatic wait_grant();
    int unsigned t = 0;
    while (gnt == 4'b0 && t < 200) begin @(negedge clk); t++; end
    chk("grant_timeout", 32'(gnt != 4'b0), 32'd1);
  endtask

  task automatic wait_ndone(input int target);
    int unsigned t = 0;
    while (ndone < target && t < 300) begin @(negedge clk); t++; end
    chk("done_timeout", 32'(ndone >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"},  32'(cnt),  32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] rr_order [5];

  initial begin
    rst = 1'b1; req = '0; len_in = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Length 3 to requester 0; req dropped and len_in changed after the grant.
    len_in = 16'h0003; req = 4'b0001;
    push(4'b0001, 3, -1);
    wait_grant();
    req = 4'b0000; len_in = 16'h000F;
    wait_ndone(1);

    // Length 0 to requester 2.
    @(negedge clk);
    len_in = 16'h0000; req = 4'b0100;
    push(4'b0100, 0, -1);
    wait_grant();
    req = 4'b0000;
    wait_ndone(2);

    // All requesters held, all lengths 1.
    reset_pulse();
`ifdef COUNTDOWN_ARB_RR_EN
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    len_in = 16'h1111; req = 4'b1111;
    for (int i = 0; i < 5; i++) push(rr_order[i], 1, (i == 0) ? -1 : 1);
    wait_ndone(7);
    req = 4'b0000;

    // Reset mid-countdown at cnt=5 of length 9, then a clean restart.
    repeat (2) @(negedge clk);
    len_in = 16'h0009; req = 4'b0001;
    wait_grant();
    req = 4'b0000;
    begin
      int unsigned t = 0;
      while (cnt != 4'd5 && t < 50) begin @(negedge clk); t++; end
      chk("reach_cnt5", 32'(cnt), 32'd5);
    end
    rst = 1'b1;
    #1 check_reset_outputs("midcount_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_done_after_abort", 32'(ndone), 32'd7);
    len_in = 16'h0002; req = 4'b0001;
    push(4'b0001, 2, -1);
    wait_grant();
    req = 4'b0000;
    wait_ndone(8);

    // Requester 1 drops mid-count while requester 3 raises; 3 follows after one idle cycle.
    @(negedge clk);
    len_in = 16'h0020; req = 4'b0010;
    push(4'b0010, 2, -1);
    wait_grant();
    @(negedge clk);
    req = 4'b1000; len_in = 16'h1070;
    push(4'b1000, 1, 1);
    wait_ndone(10);
    req = 4'b0000;

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
